fb_port_arbiter: RTL and testbench
==================================

Name: fb_port_arbiter

Overview:
- Shares one single-port synchronous frame-buffer RAM (160x120 = 19200 words) between two requesters: the camera capture writer and the VGA display reader.
- Reads have priority, because display timing is fixed. Writes are absorbed by a small FIFO and drained in idle cycles.
- A starvation guard forces a write slot when reads monopolise the port.
- Sits between the capture path, the display address path and the frame-buffer RAM.

Parameters:
- ADDR_W, 15, width of frame-buffer word address.
- DATA_W, 8, pixel word width.
- FB_DEPTH, 19200, number of valid frame-buffer words. Addresses >= FB_DEPTH are out of range.
- WFIFO_DEPTH, 4, write FIFO entries. Must be a power of 2.
- STARVE_LIMIT, 8, number of consecutive read grants with writes pending that forces one write slot.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_req  in  1  capture writer presents a pixel.
- wr_addr  in  ADDR_W  write word address.
- wr_data  in  DATA_W  write pixel.
- wr_ready  out  1  FIFO not full; a push occurs when wr_req && wr_ready.
- rd_req  in  1  display reader requests a word.
- rd_addr  in  ADDR_W  read word address.
- rd_gnt  out  1  read accepted this cycle (combinational).
- rd_valid  out  1  rd_data valid.
- rd_data  out  DATA_W  read pixel.
- mem_addr  out  ADDR_W  RAM address (registered).
- mem_we  out  1  RAM write enable (registered).
- mem_wdata  out  DATA_W  RAM write data (registered).
- mem_rdata  in  DATA_W  RAM read data, valid one cycle after the address is presented.
- wr_overflow  out  1  sticky: wr_req seen while wr_ready=0.
- wr_drop  out  1  sticky: an out-of-range write was discarded.

Behaviour:
- Reset: all registered outputs are 0, the FIFO is empty, the starvation counter is 0, and in-flight reads are cancelled (no rd_valid after reset). wr_ready=1 in the first cycle after reset.
- Reset mid-operation: flushes queued writes without committing them, and mem_we=0 from the next cycle.

FIFO:
- wr_ready = !full.
- Push on wr_req && wr_ready.
- Pop only when the arbiter issues a write.
- No bypass: a pixel pushed into an empty FIFO can be issued at the earliest the following cycle.
- When full, wr_ready=0 even if a pop occurs in the same cycle.
- wr_req while full sets wr_overflow. The data is lost.

Arbiter, evaluated each cycle; state is the starvation counter sc:
- grant_rd = rd_req && !(fifo_nonempty && sc == STARVE_LIMIT).
- grant_wr = fifo_nonempty && !grant_rd.
- rd_gnt = grant_rd. A reader not granted must hold rd_req and rd_addr until granted.
- sc increments (saturating at STARVE_LIMIT) on each cycle with grant_rd && fifo_nonempty.
- sc clears on any grant_wr, or when the FIFO is empty.

Issue, registered into the mem_* outputs on the next edge:
- grant_rd: mem_addr=rd_addr, mem_we=0.
- grant_wr: mem_addr=head addr, mem_wdata=head data, mem_we = (head addr < FB_DEPTH). An out-of-range head is popped with mem_we=0 and sets wr_drop.
- Neither: mem_we=0; mem_addr and mem_wdata hold their previous values.

Read latency:
- rd_gnt in cycle N; mem_addr presented in N+1; rd_valid=1 in N+2 with rd_data=mem_rdata.
- If rd_addr >= FB_DEPTH, the read is still granted and the slot is still consumed, but rd_data=0 in N+2.
- Back-to-back grants give one rd_valid per cycle, in order.

Write-then-read of the same address:
- A read granted in the cycle after a write issue observes the new data (RAM write-first not required, since the accesses are in separate cycles).
- A write still in the FIFO is not visible to reads.

Widths:
- The address compare is unsigned at ADDR_W. No arithmetic wraps.
- FIFO pointers are log2(WFIFO_DEPTH)+1 bits, with full/empty decided by the MSB compare.

Sticky flags wr_overflow and wr_drop clear only on rst.

Test Plan:
- Reset then idle: after rst=1 for 2 cycles, all outputs are 0 except wr_ready=1. mem_we stays 0 for 10 idle cycles.
- Single write then read: wr_req addr 100 data 0x5A at cycle 0 → mem_we=1, mem_addr=100 at cycle 2. rd_req addr 100 at cycle 3 → rd_gnt=1, rd_valid=1 with rd_data=0x5A at cycle 5.
- Continuous rd_req with 4 queued writes, STARVE_LIMIT=8 → rd_gnt drops for exactly 1 cycle after 8 consecutive grants. One write is issued per forced slot, and all 4 writes complete by cycle 40. Read data order is preserved.
- FIFO full: hold rd_req=1 with STARVE_LIMIT large and push 5 writes → wr_ready=0 after the 4th push. The 5th push sets wr_overflow=1. The first 4 writes commit after rd_req drops.
- Out-of-range: write addr 19200 → mem_we stays 0 and wr_drop=1. Read addr 19250 → rd_valid=1 with rd_data=0, 2 cycles after rd_gnt.
- Reset mid-operation: 3 writes queued plus a read granted the cycle before rst → no rd_valid and no mem_we=1 after rst. FIFO is empty and wr_ready=1.

Source files
------------

// File: rtl/fb_port_arbiter.sv
// Arbitrates one single-port frame-buffer RAM between the display reader (priority)
// and the capture writer (buffered through a small FIFO, with a starvation guard).
module fb_port_arbiter #(
    parameter int ADDR_W       = 15,
    parameter int DATA_W       = 8,
    parameter int FB_DEPTH     = 19200,
    parameter int WFIFO_DEPTH  = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_gnt,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              wr_overflow,
    output logic              wr_drop
);

    localparam int IDX_W = $clog2(WFIFO_DEPTH);
    localparam int PTR_W = IDX_W + 1;
    localparam int SC_W  = $clog2(STARVE_LIMIT + 1);

    localparam logic [ADDR_W-1:0] FB_END = ADDR_W'(FB_DEPTH);
    localparam logic [SC_W-1:0]   SC_MAX = SC_W'(STARVE_LIMIT);

    logic [ADDR_W-1:0] fifo_addr [WFIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data [WFIFO_DEPTH];
    logic [PTR_W-1:0]  wp;
    logic [PTR_W-1:0]  rp;
    logic [SC_W-1:0]   sc;

    logic              empty;
    logic              full;
    logic              push;
    logic              grant_rd;
    logic              grant_wr;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;
    logic              head_in_range;

    // Read pipeline: stage 1 tracks the cycle the address is on the RAM port.
    logic              rd_pend;
    logic              rd_pend_oor;
    logic              rd_oor;

    assign empty    = (wp == rp);
    assign full     = (wp[PTR_W-1] != rp[PTR_W-1]) && (wp[IDX_W-1:0] == rp[IDX_W-1:0]);
    assign wr_ready = !full;
    assign push     = wr_req && !full;

    assign head_addr     = fifo_addr[rp[IDX_W-1:0]];
    assign head_data     = fifo_data[rp[IDX_W-1:0]];
    assign head_in_range = (head_addr < FB_END);

    assign grant_rd = rd_req && !(!empty && (sc == SC_MAX));
    assign grant_wr = !empty && !grant_rd;
    assign rd_gnt   = grant_rd;

    // RAM data arrives combinationally in the rd_valid cycle; out-of-range reads return zero.
    assign rd_data = (rd_valid && !rd_oor) ? mem_rdata : '0;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wp[IDX_W-1:0]] <= wr_addr;
            fifo_data[wp[IDX_W-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wp          <= '0;
            rp          <= '0;
            sc          <= '0;
            mem_addr    <= '0;
            mem_we      <= 1'b0;
            mem_wdata   <= '0;
            rd_pend     <= 1'b0;
            rd_pend_oor <= 1'b0;
            rd_valid    <= 1'b0;
            rd_oor      <= 1'b0;
            wr_overflow <= 1'b0;
            wr_drop     <= 1'b0;
        end else begin
            if (push) begin
                wp <= wp + 1'b1;
            end
            if (wr_req && full) begin
                wr_overflow <= 1'b1;
            end

            if (grant_wr || empty) begin
                sc <= '0;
            end else if (grant_rd && (sc != SC_MAX)) begin
                sc <= sc + 1'b1;
            end

            mem_we <= 1'b0;
            if (grant_wr) begin
                rp        <= rp + 1'b1;
                mem_addr  <= head_addr;
                mem_wdata <= head_data;
                mem_we    <= head_in_range;
                if (!head_in_range) begin
                    wr_drop <= 1'b1;
                end
            end else if (grant_rd) begin
                mem_addr <= rd_addr;
            end

            rd_pend     <= grant_rd;
            rd_pend_oor <= grant_rd && (rd_addr >= FB_END);
            rd_valid    <= rd_pend;
            rd_oor      <= rd_pend_oor;
        end
    end

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Bench for fb_port_arbiter: a behavioural RAM plus a queue-based reference model
// compared every cycle, with directed scenarios followed by randomized traffic.
module tb_fb_port_arbiter;

    localparam int AW = 15;
    localparam int DW = 8;
    localparam int FB = 19200;
    localparam int FD = 4;
    localparam int SL = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_req;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_ready;
    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic          rd_gnt;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          wr_overflow;
    logic          wr_drop;

    always #5 clk = ~clk;

    fb_port_arbiter #(
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .FB_DEPTH    (FB),
        .WFIFO_DEPTH (FD),
        .STARVE_LIMIT(SL)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_req     (wr_req),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .rd_req     (rd_req),
        .rd_addr    (rd_addr),
        .rd_gnt     (rd_gnt),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .wr_overflow(wr_overflow),
        .wr_drop    (wr_drop)
    );

    // Single-port synchronous RAM, preloaded with a known pattern on the first edge.
    logic [DW-1:0] ram [0:(1<<AW)-1];
    logic          ram_ready = 1'b0;

    always @(posedge clk) begin
        if (!ram_ready) begin
            for (int i = 0; i < (1 << AW); i++) ram[i] <= DW'(i * 7 + 3);
            ram_ready <= 1'b1;
        end else begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            mem_rdata <= ram[mem_addr];
        end
    end

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    wr_t           wq[$];
    logic [DW-1:0] shadow [0:FB-1];
    int            sc_m;
    logic          e_mem_we;
    logic [AW-1:0] e_mem_addr;
    logic [DW-1:0] e_mem_wdata;
    logic          p1_v, p2_v;
    logic [DW-1:0] p1_d, p2_d;
    logic          e_ovf, e_drop;
    logic          armed;
    logic          last_gnt;
    int            gnt_low_cnt, we_cnt, rv_cnt;
    int            vectors, miscompares;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: compare outputs against the model, advance the model, move to next cycle.
    task automatic tick();
        bit  nonempty, full, gr, gw;
        wr_t h;
        @(negedge clk);
        nonempty = (wq.size() > 0);
        full     = (wq.size() == FD);
        gr       = rd_req && !(nonempty && sc_m == SL);
        gw       = nonempty && !gr;
        last_gnt = rd_gnt;
        if (armed) begin
            chk("wr_ready", wr_ready, !full);
            chk("rd_gnt", rd_gnt, gr);
            chk("mem_we", mem_we, e_mem_we);
            chk("mem_addr", mem_addr, e_mem_addr);
            chk("mem_wdata", mem_wdata, e_mem_wdata);
            chk("rd_valid", rd_valid, p2_v);
            if (p2_v) chk("rd_data", rd_data, p2_d);
            chk("wr_overflow", wr_overflow, e_ovf);
            chk("wr_drop", wr_drop, e_drop);
        end
        if (rd_req && !rd_gnt) gnt_low_cnt++;
        if (mem_we) we_cnt++;
        if (rd_valid) rv_cnt++;

        if (rst) begin
            wq.delete();
            sc_m = 0;
            e_mem_we = 1'b0; e_mem_addr = '0; e_mem_wdata = '0;
            p1_v = 1'b0; p2_v = 1'b0; p1_d = '0; p2_d = '0;
            e_ovf = 1'b0; e_drop = 1'b0;
            armed = 1'b1;
        end else begin
            p2_v = p1_v;
            p2_d = p1_d;
            p1_v = gr;
            p1_d = '0;
            if (gr && rd_addr < FB) p1_d = shadow[rd_addr];
            e_mem_we = 1'b0;
            if (gw) begin
                h = wq.pop_front();
                e_mem_addr  = h.a;
                e_mem_wdata = h.d;
                if (h.a < FB) begin
                    e_mem_we = 1'b1;
                    shadow[h.a] = h.d;
                end else begin
                    e_drop = 1'b1;
                end
            end else if (gr) begin
                e_mem_addr = rd_addr;
            end
            if (gw || !nonempty) sc_m = 0;
            else if (gr) sc_m = (sc_m < SL) ? sc_m + 1 : SL;
            if (wr_req) begin
                if (full) e_ovf = 1'b1;
                else wq.push_back('{a: wr_addr, d: wr_data});
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int  first_gap;
        int  rd_pct;
        logic hold;

        for (int i = 0; i < FB; i++) shadow[i] = DW'(i * 7 + 3);
        vectors = 0; miscompares = 0; armed = 1'b0; last_gnt = 1'b0;
        gnt_low_cnt = 0; we_cnt = 0; rv_cnt = 0;
        rst = 1'b1; wr_req = 1'b0; wr_addr = '0; wr_data = '0; rd_req = 1'b0; rd_addr = '0;
        @(posedge clk); #1;

        // Reset then idle
        tick(); tick();
        rst = 1'b0;
        chk("rst_wr_ready", wr_ready, 1);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_flags", {wr_overflow, wr_drop}, 0);
        we_cnt = 0;
        repeat (10) tick();
        chk("idle_we_cnt", we_cnt, 0);

        // Single write then read of address 100
        wr_req = 1'b1; wr_addr = 15'd100; wr_data = 8'h5A;
        tick();
        wr_req = 1'b0;
        tick();
        chk("wr_issue_we", mem_we, 1);
        chk("wr_issue_addr", mem_addr, 100);
        chk("wr_issue_data", mem_wdata, 8'h5A);
        tick();
        rd_req = 1'b1; rd_addr = 15'd100;
        tick();
        chk("rd_gnt_c3", last_gnt, 1);
        rd_req = 1'b0;
        tick();
        chk("rd_valid_c5", rd_valid, 1);
        chk("rd_data_c5", rd_data, 8'h5A);
        repeat (3) tick();

        // Starvation guard: continuous reads with 4 queued writes
        gnt_low_cnt = 0; we_cnt = 0; first_gap = -1;
        rd_req = 1'b1; rd_addr = 15'($urandom_range(0, 63));
        for (int c = 0; c < 45; c++) begin
            wr_req  = (c < 4);
            wr_addr = 15'(200 + c);
            wr_data = 8'($urandom);
            tick();
            if (!last_gnt && first_gap < 0) first_gap = c;
            if (last_gnt) rd_addr = 15'($urandom_range(0, 250));
        end
        wr_req = 1'b0; rd_req = 1'b0;
        chk("starve_gaps", gnt_low_cnt, 4);
        chk("starve_first_gap", first_gap, 9);
        chk("starve_writes", we_cnt, 4);
        repeat (3) tick();

        // FIFO full with reads holding the port
        rd_req = 1'b1; rd_addr = 15'd7;
        for (int c = 0; c < 5; c++) begin
            if (c == 4) chk("full_wr_ready", wr_ready, 0);
            wr_req = 1'b1; wr_addr = 15'(300 + c); wr_data = 8'(8'hA0 + c);
            tick();
        end
        chk("full_overflow", wr_overflow, 1);
        wr_req = 1'b0; rd_req = 1'b0; we_cnt = 0;
        repeat (8) tick();
        chk("full_drain_writes", we_cnt, 4);
        chk("full_drain_ready", wr_ready, 1);

        // Out-of-range write and read
        we_cnt = 0;
        wr_req = 1'b1; wr_addr = 15'd19200; wr_data = 8'h33;
        tick();
        wr_req = 1'b0;
        repeat (4) tick();
        chk("oor_we_cnt", we_cnt, 0);
        chk("oor_drop", wr_drop, 1);
        rd_req = 1'b1; rd_addr = 15'd19250;
        tick();
        rd_req = 1'b0;
        tick();
        chk("oor_rd_valid", rd_valid, 1);
        chk("oor_rd_data", rd_data, 0);
        repeat (2) tick();

        // Reset mid-operation: 3 writes queued, read granted the cycle before reset
        rd_req = 1'b1; rd_addr = 15'd12;
        for (int c = 0; c < 3; c++) begin
            wr_req = 1'b1; wr_addr = 15'(400 + c); wr_data = 8'($urandom);
            tick();
        end
        wr_req = 1'b0;
        tick();
        chk("mid_rd_gnt", last_gnt, 1);
        rd_req = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0; we_cnt = 0; rv_cnt = 0;
        repeat (6) tick();
        chk("mid_we_cnt", we_cnt, 0);
        chk("mid_rv_cnt", rv_cnt, 0);
        chk("mid_wr_ready", wr_ready, 1);
        chk("mid_flags", {wr_overflow, wr_drop}, 0);

        // Randomized traffic, reader obeys hold-until-granted
        for (int c = 0; c < 3000; c++) begin
            rd_pct = ((c / 300) % 2) ? 95 : 40;
            hold   = rd_req && !last_gnt && !rst;
            rst    = ($urandom_range(0, 499) == 0);
            wr_req = ($urandom_range(0, 99) < 45);
            if ($urandom_range(0, 15) == 0) wr_addr = 15'(FB + $urandom_range(0, 200));
            else wr_addr = 15'($urandom_range(0, 31));
            wr_data = 8'($urandom);
            if (!hold) begin
                rd_req = ($urandom_range(0, 99) < rd_pct);
                if ($urandom_range(0, 15) == 0) rd_addr = 15'(FB + $urandom_range(0, 200));
                else rd_addr = 15'($urandom_range(0, 31));
            end
            tick();
        end
        rst = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
        repeat (20) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
